ysyx_24120013_core_ctrl: RTL and testbench
==========================================

// Module: ysyx_24120013_core_ctrl
// PURPOSE
//  Multi-cycle sequencer for the single-issue core: steps IFU -> IDU -> EXU -> LSU -> WBU once per instruction.
//  Drives fetch/LSU request handshakes and the regfile/PC write enables from the IDU command and memory class.
//  Stops on ebreak (cmd 2'b11), illegal cmd or bus timeout; a stuck bus never hangs the simulation.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max wait cycles in FETCH/MEM before ERR; legal range 1..(2**TO_WIDTH-1)
//  TO_WIDTH        8    width of the watchdog counter
//  PERF_WIDTH      32   width of the perf counters (PERF_EN only)
// PORTS
//  clk          in   1   core clock
//  rst          in   1   asynchronous, active-low reset
//  start        in   1   leave IDLE and begin fetching; ignored in all other states
//  ifu_req      out  1   fetch request, held high in FETCH
//  ifu_rvalid   in   1   fetch data valid; completes the fetch
//  inst_we      out  1   latch instruction register (= FETCH & ifu_rvalid)
//  idu_command  in   2   IDU class: 00 illegal, 01 ALU-imm, 10 reserved(ALU), 11 system/ebreak
//  idu_mem      in   2   memory class: 00 none, 01 load, 10 store, 11 illegal
//  lsu_req      out  1   LSU request, held high in MEM
//  lsu_rvalid   in   1   LSU access done
//  rf_we        out  1   regfile write enable (one-cycle pulse in WB, not for stores)
//  pc_we        out  1   PC update enable (one-cycle pulse in WB)
//  halt         out  1   core stopped (HALT or ERR), sticky until reset
//  err          out  1   stop was caused by illegal/timeout, sticky until reset
//  state_o      out  3   current state encoding, for trace/difftest
//  cycle_cnt    out  PERF_WIDTH  cycles since leaving IDLE (PERF_EN only)
//  instret_cnt  out  PERF_WIDTH  retired instructions (PERF_EN only)
// BEHAVIOUR
//  - States (state_o): IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6 ERR=7. Registered; all other outputs decoded.
//  - Reset (rst=0, any cycle, mid-op included): state=IDLE, wdog=0, perf counters=0; every output 0.
//  - IDLE: start=1 -> FETCH next cycle.
//  - FETCH: ifu_req=1; ifu_rvalid=1 -> inst_we=1 same cycle, -> DECODE. Same-cycle rvalid allowed.
//  - DECODE (1 cycle): cmd 00 -> ERR; cmd 11 -> HALT; cmd 01/10 -> EXEC.
//  - EXEC (1 cycle): mem 00 -> WB; 01/10 -> MEM; 11 -> ERR.
//  - MEM: lsu_req=1; lsu_rvalid=1 -> WB.
//  - WB (1 cycle): pc_we=1; rf_we=1 unless idu_mem==10; -> FETCH.
//  - HALT: halt=1, err=0; ERR: halt=1, err=1. Both absorbing; start ignored.
//  - Watchdog: counts cycles spent in FETCH or MEM without rvalid, cleared on every state change;
//    when count==TIMEOUT_CYCLES-1 and rvalid still 0 -> ERR next cycle. rvalid on that same cycle wins (normal path).
//  - rvalid outside FETCH/MEM is ignored; idu_* only sampled in DECODE/EXEC/WB (held stable by IDU).
//  - Min latency with same-cycle rvalid: ALU instr 4 cycles (F,D,E,W); load/store 5 cycles.
// CONFIGURATION
//  - Macro YSYX_24120013_CTRL_PERF_EN.
//    Defined: cycle_cnt increments every cycle in states 1..5; instret_cnt increments on each WB cycle
//      and on the DECODE->HALT transition (ebreak retires). Both wrap at 2**PERF_WIDTH; frozen in HALT/ERR.
//    Undefined: counters and their ports are absent; sequencing identical.
// STRUCTURE
//  - Shared defs package/header ysyx_24120013_defs: state encodings, idu_command codes (CMD_ILL/ALU/RSV/SYS),
//    idu_mem codes (MEM_NONE/LOAD/STORE/ILL); IDU and this block both use it.
//  - One sub-module: ysyx_24120013_wdog (clear, enable, TIMEOUT_CYCLES compare -> expired).
// TESTING
//  - Reset then start=1, rvalid same cycle, cmd=01 mem=00: states 1,2,3,5,1; rf_we=pc_we=1 only in cycle 4.
//  - Load: ifu_rvalid after 3 cycles, mem=01, lsu_rvalid after 2 -> MEM held 3 cycles, rf_we=1 in WB; store mem=10 -> rf_we=0, pc_we=1.
//  - cmd=11 in DECODE -> HALT, halt=1 err=0; further start/rvalid pulses change nothing; PERF_EN: instret+1.
//  - cmd=00 -> ERR; mem=11 in EXEC -> ERR; halt=err=1 sticky.
//  - TIMEOUT_CYCLES=4, ifu_rvalid never -> ERR after exactly 4 FETCH cycles; rvalid in 4th cycle -> DECODE instead.
//  - rst low asserted mid-MEM (asynchronously, between clock edges) -> outputs 0 immediately, state_o=0; restart after start runs cleanly.

Source files
------------

// File: rtl/ysyx_24120013_defs.sv
// rtl/ysyx_24120013_defs.sv - shared sequencer state, IDU command and memory-class encodings
package ysyx_24120013_defs;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

  localparam logic [1:0] CMD_ILL = 2'b00;
  localparam logic [1:0] CMD_ALU = 2'b01;
  localparam logic [1:0] CMD_RSV = 2'b10;
  localparam logic [1:0] CMD_SYS = 2'b11;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_LOAD  = 2'b01;
  localparam logic [1:0] MEM_STORE = 2'b10;
  localparam logic [1:0] MEM_ILL   = 2'b11;

  // States that wait on a bus handshake and are therefore watched by the watchdog.
  function automatic logic is_wait_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/ysyx_24120013_wdog.sv
// rtl/ysyx_24120013_wdog.sv - bus wait watchdog; expired on the last allowed wait cycle
module ysyx_24120013_wdog #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [TO_WIDTH-1:0] LIMIT = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [TO_WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/ysyx_24120013_core_ctrl.sv
// rtl/ysyx_24120013_core_ctrl.sv - multi-cycle IFU/IDU/EXU/LSU/WBU sequencer
// Optional perf counters: YSYX_24120013_CTRL_PERF_EN
module ysyx_24120013_core_ctrl
  import ysyx_24120013_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
`ifdef YSYX_24120013_CTRL_PERF_EN
  ,parameter int PERF_WIDTH    = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       ifu_req,
  input  logic       ifu_rvalid,
  output logic       inst_we,
  input  logic [1:0] idu_command,
  input  logic [1:0] idu_mem,
  output logic       lsu_req,
  input  logic       lsu_rvalid,
  output logic       rf_we,
  output logic       pc_we,
  output logic       halt,
  output logic       err,
  output logic [2:0] state_o
`ifdef YSYX_24120013_CTRL_PERF_EN
  ,output logic [PERF_WIDTH-1:0] cycle_cnt,
  output logic [PERF_WIDTH-1:0] instret_cnt
`endif
);

  state_e r_state;
  state_e w_next;
  logic   w_rvalid;
  logic   w_wd_en;
  logic   w_wd_clear;
  logic   w_wd_expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_rvalid   = (r_state == ST_MEM) ? lsu_rvalid : ifu_rvalid;
  assign w_wd_en    = is_wait_state(r_state) && !w_rvalid;
  assign w_wd_clear = (w_next != r_state);

  ysyx_24120013_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_WIDTH      (TO_WIDTH)
  ) u_wdog (
    .clk      (clk),
    .rst_n    (rst),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_en),
    .o_expired(w_wd_expired)
  );

  always_comb begin
    w_next  = r_state;
    ifu_req = 1'b0;
    inst_we = 1'b0;
    lsu_req = 1'b0;
    rf_we   = 1'b0;
    pc_we   = 1'b0;
    halt    = 1'b0;
    err     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        ifu_req = 1'b1;
        if (ifu_rvalid) begin
          inst_we = 1'b1;
          w_next  = ST_DECODE;
        end else if (w_wd_expired) begin
          w_next = ST_ERR;
        end
      end
      ST_DECODE: begin
        case (idu_command)
          CMD_ILL: w_next = ST_ERR;
          CMD_SYS: w_next = ST_HALT;
          default: w_next = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (idu_mem)
          MEM_NONE:            w_next = ST_WB;
          MEM_LOAD, MEM_STORE: w_next = ST_MEM;
          default:             w_next = ST_ERR;
        endcase
      end
      ST_MEM: begin
        lsu_req = 1'b1;
        if (lsu_rvalid) begin
          w_next = ST_WB;
        end else if (w_wd_expired) begin
          w_next = ST_ERR;
        end
      end
      ST_WB: begin
        pc_we  = 1'b1;
        rf_we  = (idu_mem != MEM_STORE);
        w_next = ST_FETCH;
      end
      ST_HALT: begin
        halt = 1'b1;
      end
      ST_ERR: begin
        halt = 1'b1;
        err  = 1'b1;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign state_o = r_state;

`ifdef YSYX_24120013_CTRL_PERF_EN
  logic [PERF_WIDTH-1:0] r_cycle_cnt;
  logic [PERF_WIDTH-1:0] r_instret_cnt;
  logic                  w_busy;
  logic                  w_retire;

  assign w_busy   = (r_state != ST_IDLE) && (r_state != ST_HALT) && (r_state != ST_ERR);
  // ebreak retires on its way into HALT even though it never reaches WB.
  assign w_retire = (r_state == ST_WB) || ((r_state == ST_DECODE) && (w_next == ST_HALT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
    end else begin
      if (w_busy)   r_cycle_cnt   <= r_cycle_cnt + 1'b1;
      if (w_retire) r_instret_cnt <= r_instret_cnt + 1'b1;
    end
  end

  assign cycle_cnt   = r_cycle_cnt;
  assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: tb/tb_ysyx_24120013_core_ctrl.sv
// tb/tb_ysyx_24120013_core_ctrl.sv - directed self-checking bench for the core sequencer
module tb_ysyx_24120013_core_ctrl;

  localparam int TO = 4;

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] FREQ = 7'b1000000;
  localparam logic [6:0] FTCH = 7'b1100000;
  localparam logic [6:0] LREQ = 7'b0010000;
  localparam logic [6:0] WBRF = 7'b0001100;
  localparam logic [6:0] WBPC = 7'b0000100;
  localparam logic [6:0] HLT  = 7'b0000010;
  localparam logic [6:0] ERRO = 7'b0000011;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       ifu_req;
  logic       ifu_rvalid;
  logic       inst_we;
  logic [1:0] idu_command;
  logic [1:0] idu_mem;
  logic       lsu_req;
  logic       lsu_rvalid;
  logic       rf_we;
  logic       pc_we;
  logic       halt;
  logic       err;
  logic [2:0] state_o;
`ifdef YSYX_24120013_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_24120013_core_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .TO_WIDTH      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ifu_req    (ifu_req),
    .ifu_rvalid (ifu_rvalid),
    .inst_we    (inst_we),
    .idu_command(idu_command),
    .idu_mem    (idu_mem),
    .lsu_req    (lsu_req),
    .lsu_rvalid (lsu_rvalid),
    .rf_we      (rf_we),
    .pc_we      (pc_we),
    .halt       (halt),
    .err        (err),
    .state_o    (state_o)
`ifdef YSYX_24120013_CTRL_PERF_EN
    ,.cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  task automatic cmp(input string tag, input logic [2:0] st, input logic [6:0] o);
    logic [9:0] got;
    logic [9:0] exp;
    got = {state_o, ifu_req, inst_we, lsu_req, rf_we, pc_we, halt, err};
    exp = {st, o};
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed state=%0d outs=%b expected state=%0d outs=%b",
             tag, got[9:7], got[6:0], exp[9:7], exp[6:0]);
    end
  endtask

  task automatic step(input logic s, input logic f, input logic [1:0] c, input logic [1:0] m,
                      input logic l, input logic [2:0] st, input logic [6:0] o, input string tag);
    @(negedge clk);
    start       = s;
    ifu_rvalid  = f;
    idu_command = c;
    idu_mem     = m;
    lsu_rvalid  = l;
    #1;
    cmp(tag, st, o);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0; ifu_rvalid = 1'b0; lsu_rvalid = 1'b0;
    idu_command = 2'b00; idu_mem = 2'b00;
    #1;
    cmp(tag, 3'd0, NONE);
    @(negedge clk);
    rst = 1'b1;
  endtask

`ifdef YSYX_24120013_CTRL_PERF_EN
  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    start = 1'b0; ifu_rvalid = 1'b0; lsu_rvalid = 1'b0;
    idu_command = 2'b00; idu_mem = 2'b00;
    #2;
    cmp("reset", 3'd0, NONE);
`ifdef YSYX_24120013_CTRL_PERF_EN
    chk_val("reset cycle", cycle_cnt, 32'd0);
    chk_val("reset instret", instret_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // ALU-imm, minimum latency
    step(1, 0, 2'b01, 2'b00, 0, 3'd0, NONE, "alu idle");
    step(0, 1, 2'b01, 2'b00, 0, 3'd1, FTCH, "alu fetch");
    step(0, 0, 2'b01, 2'b00, 0, 3'd2, NONE, "alu decode");
    step(0, 0, 2'b01, 2'b00, 0, 3'd3, NONE, "alu exec");
    step(0, 0, 2'b01, 2'b00, 0, 3'd5, WBRF, "alu wb");
    // load with slow fetch and slow LSU
    step(0, 0, 2'b01, 2'b01, 0, 3'd1, FREQ, "ld fetch1");
    step(0, 0, 2'b01, 2'b01, 0, 3'd1, FREQ, "ld fetch2");
    step(0, 1, 2'b01, 2'b01, 0, 3'd1, FTCH, "ld fetch3");
    step(0, 0, 2'b01, 2'b01, 0, 3'd2, NONE, "ld decode");
    step(0, 0, 2'b01, 2'b01, 0, 3'd3, NONE, "ld exec");
    step(0, 0, 2'b01, 2'b01, 0, 3'd4, LREQ, "ld mem1");
    step(0, 0, 2'b01, 2'b01, 0, 3'd4, LREQ, "ld mem2");
    step(0, 0, 2'b01, 2'b01, 1, 3'd4, LREQ, "ld mem3");
    step(0, 0, 2'b01, 2'b01, 0, 3'd5, WBRF, "ld wb");
    // store through the reserved ALU command
    step(0, 1, 2'b10, 2'b10, 0, 3'd1, FTCH, "st fetch");
    step(0, 0, 2'b10, 2'b10, 0, 3'd2, NONE, "st decode");
    step(0, 0, 2'b10, 2'b10, 0, 3'd3, NONE, "st exec");
    step(0, 0, 2'b10, 2'b10, 1, 3'd4, LREQ, "st mem");
    step(0, 0, 2'b10, 2'b10, 0, 3'd5, WBPC, "st wb");
    // rvalid on the last watchdog cycle wins
    step(0, 0, 2'b11, 2'b00, 0, 3'd1, FREQ, "edge fetch1");
    step(0, 0, 2'b11, 2'b00, 0, 3'd1, FREQ, "edge fetch2");
    step(0, 0, 2'b11, 2'b00, 0, 3'd1, FREQ, "edge fetch3");
    step(0, 1, 2'b11, 2'b00, 0, 3'd1, FTCH, "edge fetch4");
    step(0, 0, 2'b11, 2'b00, 0, 3'd2, NONE, "eb decode");
    step(0, 0, 2'b11, 2'b00, 0, 3'd6, HLT,  "halt");
    step(1, 1, 2'b00, 2'b00, 1, 3'd6, HLT,  "halt pulse1");
    step(1, 1, 2'b01, 2'b01, 1, 3'd6, HLT,  "halt pulse2");
`ifdef YSYX_24120013_CTRL_PERF_EN
    chk_val("halt cycle", cycle_cnt, 32'd23);
    chk_val("halt instret", instret_cnt, 32'd4);
`endif

    // illegal command
    do_reset("reset ill");
    step(1, 0, 2'b00, 2'b00, 0, 3'd0, NONE, "ill idle");
    step(0, 1, 2'b00, 2'b00, 0, 3'd1, FTCH, "ill fetch");
    step(0, 0, 2'b00, 2'b00, 0, 3'd2, NONE, "ill decode");
    step(1, 1, 2'b00, 2'b00, 1, 3'd7, ERRO, "ill err");
    step(1, 0, 2'b01, 2'b00, 0, 3'd7, ERRO, "ill sticky");

    // illegal memory class
    do_reset("reset memill");
    step(1, 0, 2'b01, 2'b11, 0, 3'd0, NONE, "memill idle");
    step(0, 1, 2'b01, 2'b11, 0, 3'd1, FTCH, "memill fetch");
    step(0, 0, 2'b01, 2'b11, 0, 3'd2, NONE, "memill decode");
    step(0, 0, 2'b01, 2'b11, 0, 3'd3, NONE, "memill exec");
    step(0, 0, 2'b01, 2'b11, 0, 3'd7, ERRO, "memill err");

    // fetch timeout
    do_reset("reset to");
    step(1, 0, 2'b01, 2'b00, 0, 3'd0, NONE, "to idle");
    step(0, 0, 2'b01, 2'b00, 0, 3'd1, FREQ, "to fetch1");
    step(0, 0, 2'b01, 2'b00, 0, 3'd1, FREQ, "to fetch2");
    step(0, 0, 2'b01, 2'b00, 0, 3'd1, FREQ, "to fetch3");
    step(0, 0, 2'b01, 2'b00, 0, 3'd1, FREQ, "to fetch4");
    step(0, 1, 2'b01, 2'b00, 0, 3'd7, ERRO, "to err");

    // asynchronous reset in the middle of MEM, then a clean restart
    do_reset("reset async");
    step(1, 0, 2'b01, 2'b01, 0, 3'd0, NONE, "ar idle");
    step(0, 1, 2'b01, 2'b01, 0, 3'd1, FTCH, "ar fetch");
    step(0, 0, 2'b01, 2'b01, 0, 3'd2, NONE, "ar decode");
    step(0, 0, 2'b01, 2'b01, 0, 3'd3, NONE, "ar exec");
    step(0, 0, 2'b01, 2'b01, 0, 3'd4, LREQ, "ar mem");
    #2;
    rst = 1'b0;
    #1;
    cmp("async rst", 3'd0, NONE);
`ifdef YSYX_24120013_CTRL_PERF_EN
    chk_val("async cycle", cycle_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    step(1, 0, 2'b01, 2'b00, 0, 3'd0, NONE, "re idle");
    step(0, 1, 2'b01, 2'b00, 0, 3'd1, FTCH, "re fetch");
    step(0, 0, 2'b01, 2'b00, 0, 3'd2, NONE, "re decode");
    step(0, 0, 2'b01, 2'b00, 0, 3'd3, NONE, "re exec");
    step(0, 0, 2'b01, 2'b00, 0, 3'd5, WBRF, "re wb");
    step(0, 0, 2'b01, 2'b00, 0, 3'd1, FREQ, "re fetch2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
